// File: rtl/mandel_result_streamer.sv
// Captures finished-pixel iteration counts into a small FIFO and streams each record out as 4-bit nibbles, MS first.
// Optional build macro MANDEL_SEQ_TAG_EN prepends a 4-bit sequence tag nibble to every record.
module mandel_result_streamer #(
    parameter int unsigned CTRWIDTH = 7,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    px_valid,
    input  logic [CTRWIDTH-1:0]     px_ctr,
    input  logic [CTRWIDTH-1:0]     max_ctr,
    output logic [3:0]              nib_out,
    output logic                    nib_valid,
    input  logic                    nib_ready,
    output logic                    nib_last,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    input  logic                    clr_ovf,
    output logic                    busy
);

    localparam int unsigned W         = CTRWIDTH + 1;
    localparam int unsigned NIBS      = (W + 3) / 4;
    localparam int unsigned DATA_BITS = NIBS * 4;
`ifdef MANDEL_SEQ_TAG_EN
    localparam int unsigned TAG_NIBS  = 1;
`else
    localparam int unsigned TAG_NIBS  = 0;
`endif
    localparam int unsigned REC_NIBS  = NIBS + TAG_NIBS;
    localparam int unsigned REC_BITS  = REC_NIBS * 4;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned LVL_W     = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W     = (REC_NIBS > 1) ? $clog2(REC_NIBS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REC_NIBS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q, state_d;
    logic [REC_BITS-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     count_q, count_d;
    logic [REC_BITS-1:0]  shreg_q, shreg_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 last_q, last_d;
    logic                 ovf_q;
    logic                 busy_q;
    logic                 empty, full, push, pop, drop;
    logic [DATA_BITS-1:0] data_word;
    logic [REC_BITS-1:0]  new_rec;
    logic [REC_BITS-1:0]  head;

    // Record word {inside, count}, zero-extended to whole nibbles
    assign data_word = DATA_BITS'({(px_ctr == max_ctr), px_ctr});

`ifdef MANDEL_SEQ_TAG_EN
    logic [3:0] seq_q;

    assign new_rec = {seq_q, data_word};

    // Sequence tag advances only on accepted pushes
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q <= 4'd0;
        end else if (push) begin
            seq_q <= seq_q + 4'd1;
        end
    end
`else
    assign new_rec = data_word;
`endif

    assign empty = (count_q == '0);
    assign full  = (count_q == LVL_W'(DEPTH));
    assign head  = mem[rd_ptr_q];

    // Serializer next-state, FIFO pop/push decisions and level update
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        last_d  = last_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = head;
                    idx_d   = '0;
                    last_d  = (IDX_LAST == '0);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (nib_ready) begin
                    if (!last_q) begin
                        shreg_d = shreg_q << 4;
                        idx_d   = idx_q + IDX_W'(1);
                        last_d  = ((idx_q + IDX_W'(1)) == IDX_LAST);
                    end else if (!empty) begin
                        // Back-to-back reload keeps the stream gap-free
                        pop     = 1'b1;
                        shreg_d = head;
                        idx_d   = '0;
                        last_d  = (IDX_LAST == '0);
                    end else begin
                        shreg_d = '0;
                        idx_d   = '0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        push = px_valid & (~full | pop);
        drop = px_valid & full & ~pop;

        case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            count_q <= count_d;
            busy_q  <= (count_d != '0) | (state_d == SEND);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= new_rec;
        end
    end

    assign nib_out    = shreg_q[REC_BITS-1 -: 4];
    assign nib_valid  = (state_q == SEND);
    assign nib_last   = last_q;
    assign fifo_level = count_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mandel_result_streamer.sv
// Directed plus randomized bench for mandel_result_streamer with a queue-based nibble stream model.
module tb_mandel_result_streamer;

    localparam int unsigned CTRW  = 7;
    localparam int unsigned DEPTH = 4;

    logic            clk;
    logic            reset;
    logic            px_valid;
    logic [CTRW-1:0] px_ctr;
    logic [CTRW-1:0] max_ctr;
    logic [3:0]      nib_out;
    logic            nib_valid;
    logic            nib_ready;
    logic            nib_last;
    logic [2:0]      fifo_level;
    logic            overflow;
    logic            clr_ovf;
    logic            busy;

    int total;
    int bad;

    logic [3:0] exp_nib [$];
    bit         exp_last[$];
`ifdef MANDEL_SEQ_TAG_EN
    logic [3:0] seq_m;
`endif

    mandel_result_streamer #(.CTRWIDTH(CTRW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .px_valid   (px_valid),
        .px_ctr     (px_ctr),
        .max_ctr    (max_ctr),
        .nib_out    (nib_out),
        .nib_valid  (nib_valid),
        .nib_ready  (nib_ready),
        .nib_last   (nib_last),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        exp_nib.delete();
        exp_last.delete();
`ifdef MANDEL_SEQ_TAG_EN
        seq_m = 4'd0;
`endif
    endtask

    // Expected nibbles of one accepted pixel: optional tag, then {inside, count} MS nibble first
    task automatic model_push(input logic [CTRW-1:0] c, input logic [CTRW-1:0] m);
        logic [7:0] w;
        w = {(c == m), c};
`ifdef MANDEL_SEQ_TAG_EN
        exp_nib.push_back(seq_m);
        exp_last.push_back(1'b0);
        seq_m = seq_m + 4'd1;
`endif
        exp_nib.push_back(w[7:4]);
        exp_last.push_back(1'b0);
        exp_nib.push_back(w[3:0]);
        exp_last.push_back(1'b1);
    endtask

    task automatic drive_px(input logic [CTRW-1:0] c, input logic [CTRW-1:0] m, input bit expect_accept);
        px_ctr   = c;
        max_ctr  = m;
        px_valid = 1'b1;
        if (expect_accept) model_push(c, m);
        tick();
        px_valid = 1'b0;
    endtask

    // Consume the stream with ready held high, checking every accepted nibble
    task automatic drain(input int budget, output int gaps);
        int  left;
        bit  started;
        left    = budget;
        started = 1'b0;
        gaps    = 0;
        nib_ready = 1'b1;
        while (exp_nib.size() != 0 && left > 0) begin
            if (nib_valid) begin
                started = 1'b1;
                chk("drain_nib", 32'(nib_out), 32'(exp_nib[0]));
                chk("drain_last", 32'(nib_last), 32'(exp_last[0]));
                void'(exp_nib.pop_front());
                void'(exp_last.pop_front());
            end else if (started) begin
                gaps++;
            end
            tick();
            left--;
        end
        if (exp_nib.size() != 0) begin
            chk("drain_timeout", 32'(exp_nib.size()), 32'd0);
            exp_nib.delete();
            exp_last.delete();
        end
    endtask

    initial begin
        int gaps;
        int outstanding;
        bit prev_stall;
        logic [3:0] prev_nib;
        logic prev_last;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        px_valid = 1'b0;
        px_ctr = '0;
        max_ctr = 7'h7F;
        nib_ready = 1'b0;
        clr_ovf = 1'b0;
        model_reset();

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_nib_out", 32'(nib_out), 32'd0);
        chk("rst_nib_valid", 32'(nib_valid), 32'd0);
        chk("rst_nib_last", 32'(nib_last), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single pixel, two-cycle latency
        nib_ready = 1'b1;
        drive_px(7'h25, 7'h7F, 1'b1);
        chk("single_c1_valid", 32'(nib_valid), 32'd0);
        chk("single_c1_level", 32'(fifo_level), 32'd1);
        chk("single_c1_busy", 32'(busy), 32'd1);
        tick();
        chk("single_c2_valid", 32'(nib_valid), 32'd1);
        drain(10, gaps);
        chk("single_gaps", 32'(gaps), 32'd0);
        chk("single_end_valid", 32'(nib_valid), 32'd0);
        chk("single_end_nib", 32'(nib_out), 32'd0);
        chk("single_end_busy", 32'(busy), 32'd0);

        // Inside point
        drive_px(7'h7F, 7'h7F, 1'b1);
        drain(10, gaps);
        chk("inside_end_valid", 32'(nib_valid), 32'd0);

        // Backpressure: output holds while not ready
        nib_ready = 1'b0;
        drive_px(7'h13, 7'h7F, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(nib_valid), 32'd1);
            chk("bp_nib", 32'(nib_out), 32'(exp_nib[0]));
            chk("bp_last", 32'(nib_last), 32'(exp_last[0]));
            tick();
        end
        drain(10, gaps);
        chk("bp_gaps", 32'(gaps), 32'd0);

        // Overflow: six back-to-back pixels with the consumer stalled
        nib_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin
                chk("ovf_pre_level", 32'(fifo_level), 32'd4);
                chk("ovf_pre_flag", 32'(overflow), 32'd0);
            end
            drive_px(CTRW'(i), 7'h7F, (i <= 5));
        end
        tick();
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain(40, gaps);
        chk("ovf_drain_gaps", 32'(gaps), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Clear coincident with a drop: set wins
        nib_ready = 1'b0;
        for (int i = 7; i <= 12; i++) begin
            if (i == 12) clr_ovf = 1'b1;
            drive_px(CTRW'(i), 7'h0C, (i <= 11));
            clr_ovf = 1'b0;
        end
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        chk("ovf_set_wins_level", 32'(fifo_level), 32'd4);
        drain(40, gaps);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared2", 32'(overflow), 32'd0);

        // Back-to-back records with no bubble
        nib_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_px(CTRW'($urandom), 7'h7F, 1'b1);
        end
        repeat (2) tick();
        chk("b2b_busy_before", 32'(busy), 32'd1);
        drain(20, gaps);
        chk("b2b_gaps", 32'(gaps), 32'd0);
        chk("b2b_busy_after", 32'(busy), 32'd0);
        chk("b2b_valid_after", 32'(nib_valid), 32'd0);

        // Reset in the middle of a stalled, overflowed stream
        nib_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_px(CTRW'(i + 40), 7'h7F, 1'b0);
        end
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        model_reset();
        chk("mid_rst_valid", 32'(nib_valid), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_nib", 32'(nib_out), 32'd0);
        drive_px(7'h5A, 7'h5A, 1'b1);
        drain(10, gaps);
        chk("mid_rst_fresh_busy", 32'(busy), 32'd0);

        // Randomized traffic, pixel rate throttled so the FIFO never drops
        outstanding = 0;
        prev_stall  = 1'b0;
        prev_nib    = '0;
        prev_last   = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            nib_ready = ($urandom_range(0, 3) != 0);
            if (prev_stall) begin
                chk("rnd_hold_valid", 32'(nib_valid), 32'd1);
                chk("rnd_hold_nib", 32'(nib_out), 32'(prev_nib));
                chk("rnd_hold_last", 32'(nib_last), 32'(prev_last));
            end
            if (!nib_valid) begin
                chk("rnd_idle_nib", 32'(nib_out), 32'd0);
                chk("rnd_idle_last", 32'(nib_last), 32'd0);
            end
            if (nib_valid && nib_ready) begin
                if (exp_nib.size() == 0) begin
                    chk("rnd_extra_nib", 32'(exp_nib.size()), 32'd1);
                end else begin
                    chk("rnd_nib", 32'(nib_out), 32'(exp_nib[0]));
                    chk("rnd_last", 32'(nib_last), 32'(exp_last[0]));
                    if (exp_last[0]) outstanding--;
                    void'(exp_nib.pop_front());
                    void'(exp_last.pop_front());
                end
            end
            prev_stall = nib_valid && !nib_ready;
            prev_nib   = nib_out;
            prev_last  = nib_last;
            if (outstanding < int'(DEPTH) && $urandom_range(0, 1) == 1) begin
                px_ctr   = CTRW'($urandom);
                max_ctr  = ($urandom_range(0, 3) == 0) ? px_ctr : CTRW'($urandom);
                px_valid = 1'b1;
                model_push(px_ctr, max_ctr);
                outstanding++;
            end else begin
                px_valid = 1'b0;
            end
            tick();
        end
        px_valid = 1'b0;
        drain(200, gaps);
        chk("rnd_overflow", 32'(overflow), 32'd0);
        chk("rnd_end_busy", 32'(busy), 32'd0);
        chk("rnd_end_level", 32'(fifo_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
